// File: rtl/adder_pkg.sv
// Shared definitions for the sequential slice adder: FSM state encoding and
// default operand/slice widths.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_slice.sv
// CHUNK-bit ripple-carry adder. Also exposes the carry into its MSB so the
// caller can derive signed overflow on the most significant slice.
module adder_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [CHUNK:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < CHUNK; i++) begin
      sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = carry[CHUNK];
  assign cmsb_o = carry[CHUNK-1];

endmodule

// File: rtl/seq_adder.sv
// Sequential adder/subtractor: adds CHUNK bits per cycle through one shared
// slice adder and presents the result with a valid/ready handshake.
module seq_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : gBadParams
    $error("seq_adder: CHUNK must divide WIDTH and not exceed it");
  end

  localparam int N     = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(N - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  int               sliceShift;
  logic [CHUNK-1:0] sliceA, sliceB, sliceSum;
  logic             sliceCout, sliceCmsb;

  assign sliceShift = int'(cnt_q) * CHUNK;
  assign sliceA     = CHUNK'(opA_q >> sliceShift);
  assign sliceB     = CHUNK'(opB_q >> sliceShift);

  adder_slice #(.CHUNK(CHUNK)) u_slice (
    .a_i    (sliceA),
    .b_i    (sliceB),
    .cin_i  (carry_q),
    .sum_o  (sliceSum),
    .cout_o (sliceCout),
    .cmsb_o (sliceCmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // The visible result only changes on the final slice, so sum/cout/ovf
  // stay put while a new operation accumulates in res_q.
  always_comb begin
    state_d   = state_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    res_d     = res_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);

    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            opA_d   = a;
            opB_d   = b ^ {WIDTH{sub}};
            carry_d = sub;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          res_d   = (res_q & ~(SLICE_MASK << sliceShift))
                  | (WIDTH'(sliceSum) << sliceShift);
          carry_d = sliceCout;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            sum_d   = res_d;
            cout_d  = sliceCout;
            ovf_d   = sliceCmsb ^ sliceCout;
            cnt_d   = '0;
            state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_adder.sv
// Directed self-checking bench for seq_adder: three instances with
// CHUNK = 4, 16 and 1 driven by a single linear stimulus sequence.
module tb_seq_adder;

  logic        clk;
  logic        rst_n;
  logic        inValid  [3];
  logic        inReady  [3];
  logic [15:0] aIn      [3];
  logic [15:0] bIn      [3];
  logic        subIn    [3];
  logic        flushIn  [3];
  logic        outValid [3];
  logic        outReady [3];
  logic [15:0] sumO     [3];
  logic        coutO    [3];
  logic        ovfO     [3];

  int total = 0;
  int bad   = 0;

  seq_adder #(.WIDTH(16), .CHUNK(4)) dutC4 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .a(aIn[0]), .b(bIn[0]), .sub(subIn[0]), .flush(flushIn[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]),
    .sum(sumO[0]), .cout(coutO[0]), .ovf(ovfO[0])
  );

  seq_adder #(.WIDTH(16), .CHUNK(16)) dutC16 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .a(aIn[1]), .b(bIn[1]), .sub(subIn[1]), .flush(flushIn[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]),
    .sum(sumO[1]), .cout(coutO[1]), .ovf(ovfO[1])
  );

  seq_adder #(.WIDTH(16), .CHUNK(1)) dutC1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .a(aIn[2]), .b(bIn[2]), .sub(subIn[2]), .flush(flushIn[2]),
    .out_valid(outValid[2]), .out_ready(outReady[2]),
    .sum(sumO[2]), .cout(coutO[2]), .ovf(ovfO[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Runs one operation on instance k; hold > 0 keeps out_ready low for that
  // many cycles in DONE while offering a competing in_valid.
  task automatic applyStimulus(input int k, input logic [15:0] av,
                               input logic [15:0] bv, input logic sv,
                               input logic [15:0] eSum, input logic eCout,
                               input logic eOvf, input int lat,
                               input int hold, input string tag);
    int cycles;
    checkOutput({tag, ".inReady"}, 16'(inReady[k]), 16'd1);
    aIn[k]      = av;
    bIn[k]      = bv;
    subIn[k]    = sv;
    outReady[k] = (hold == 0);
    inValid[k]  = 1'b1;
    @(posedge clk);
    #1;
    inValid[k] = 1'b0;
    aIn[k]     = 16'hDEAD;
    bIn[k]     = 16'hBEEF;
    cycles     = 0;
    while (!outValid[k] && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput({tag, ".latency"}, 16'(cycles), 16'(lat));
    checkOutput({tag, ".sum"}, sumO[k], eSum);
    checkOutput({tag, ".cout"}, 16'(coutO[k]), 16'(eCout));
    checkOutput({tag, ".ovf"}, 16'(ovfO[k]), 16'(eOvf));
    for (int h = 0; h < hold; h++) begin
      aIn[k]     = 16'h0101;
      bIn[k]     = 16'h0202;
      inValid[k] = 1'b1;
      @(posedge clk);
      #1;
      checkOutput({tag, ".holdValid"}, 16'(outValid[k]), 16'd1);
      checkOutput({tag, ".holdSum"}, sumO[k], eSum);
      checkOutput({tag, ".holdInReady"}, 16'(inReady[k]), 16'd0);
    end
    inValid[k]  = 1'b0;
    outReady[k] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, ".consumed"}, 16'(outValid[k]), 16'd0);
    checkOutput({tag, ".idleReady"}, 16'(inReady[k]), 16'd1);
    checkOutput({tag, ".idleSum"}, sumO[k], eSum);
  endtask

  initial begin
    logic sawValid;
    for (int k = 0; k < 3; k++) begin
      inValid[k]  = 1'b0;
      aIn[k]      = '0;
      bIn[k]      = '0;
      subIn[k]    = 1'b0;
      flushIn[k]  = 1'b0;
      outReady[k] = 1'b1;
    end
    rst_n = 1'b0;
    #23;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("rst.inReady", 16'(inReady[k]), 16'd1);
      checkOutput("rst.outValid", 16'(outValid[k]), 16'd0);
      checkOutput("rst.sum", sumO[k], 16'h0000);
      checkOutput("rst.cout", 16'(coutO[k]), 16'd0);
      checkOutput("rst.ovf", 16'(ovfO[k]), 16'd0);
    end

    applyStimulus(0, 16'hCB00, 16'h1995, 1'b0, 16'hE495, 1'b0, 1'b0, 4, 0, "c4.add1");
    applyStimulus(0, 16'hCBF0, 16'h0001, 1'b0, 16'hCBF1, 1'b0, 1'b0, 4, 0, "c4.add2");
    applyStimulus(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4, 0, "c4.carry");
    applyStimulus(0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4, 0, "c4.ovf");
    applyStimulus(0, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 4, 0, "c4.sub1");
    applyStimulus(0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4, 0, "c4.sub2");
    applyStimulus(0, 16'h4321, 16'h1234, 1'b0, 16'h5555, 1'b0, 1'b0, 4, 5, "c4.backpressure");

    // Reset in the second RUN cycle discards the operation.
    aIn[0] = 16'h1111; bIn[0] = 16'h2222; subIn[0] = 1'b0; inValid[0] = 1'b1;
    @(posedge clk);
    #1;
    inValid[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rstRun.inReady", 16'(inReady[0]), 16'd1);
    checkOutput("rstRun.outValid", 16'(outValid[0]), 16'd0);
    checkOutput("rstRun.sum", sumO[0], 16'h0000);
    #1;
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      sawValid = sawValid | outValid[0];
    end
    checkOutput("rstRun.noValid", 16'(sawValid), 16'd0);

    // Flush in the second RUN cycle behaves the same way.
    aIn[0] = 16'h1111; bIn[0] = 16'h2222; inValid[0] = 1'b1;
    @(posedge clk);
    #1;
    inValid[0] = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("flush.busy", 16'(inReady[0]), 16'd0);
    flushIn[0] = 1'b1;
    @(posedge clk);
    #1;
    flushIn[0] = 1'b0;
    checkOutput("flush.inReady", 16'(inReady[0]), 16'd1);
    sawValid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      sawValid = sawValid | outValid[0];
    end
    checkOutput("flush.noValid", 16'(sawValid), 16'd0);
    applyStimulus(0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 4, 0, "c4.afterAbort");

    for (int k = 1; k < 3; k++) begin
      int lat;
      lat = (k == 1) ? 1 : 16;
      applyStimulus(k, 16'hCB00, 16'h1995, 1'b0, 16'hE495, 1'b0, 1'b0, lat, 0, "cx.add1");
      applyStimulus(k, 16'hCBF0, 16'h0001, 1'b0, 16'hCBF1, 1'b0, 1'b0, lat, 0, "cx.add2");
      applyStimulus(k, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, lat, 0, "cx.carry");
      applyStimulus(k, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, lat, 0, "cx.ovf");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_adder.md
SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per cycle; WIDTH % CHUNK != 0 or CHUNK > WIDTH SHALL be an elaboration error.
REQ-003 Ports SHALL be: clk  in  1  single clock, rising edge; all state changes on this edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  operands and mode valid.
REQ-006 in_ready  out  1  block can accept operands.
REQ-007 a, b  in  WIDTH  unsigned/two's-complement operands.
REQ-008 sub  in  1  0 = a+b, 1 = a-b.
REQ-009 flush  in  1  synchronous abort of any operation in progress.
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 sum  out  WIDTH  result, modulo 2^WIDTH.
REQ-013 cout  out  1  carry out of MSB (for sub: 1 = no borrow).
REQ-014 ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 IDLE: on in_valid && in_ready, latch a, b XOR {WIDTH{sub}}, carry register = sub, slice counter = 0, go to RUN; inputs otherwise ignored.
REQ-017 RUN: each cycle add slice [cnt*CHUNK +: CHUNK] of latched a, b plus carry register, write that slice of the result register, update carry, increment counter.
REQ-018 After the slice with cnt = N-1 (N = WIDTH/CHUNK), go to DONE; out_valid SHALL rise exactly N cycles after the accepting edge.
REQ-019 ovf SHALL be captured from the final slice: carry into bit WIDTH-1 XOR carry out.
REQ-020 DONE: out_valid = 1; sum, cout, ovf SHALL hold stable until out_valid && out_ready, then go to IDLE (in_ready = 1 the following cycle).
REQ-021 No overlap: a new operation is never accepted in the same cycle as a result handshake.
REQ-022 flush SHALL force IDLE on the next edge from any state, dropping any pending result; flush has priority over in_valid and out_ready.
REQ-023 sum/cout/ovf SHALL hold their last values in IDLE and RUN; only out_valid qualifies them.
REQ-024 CHUNK = WIDTH SHALL give latency 1; behaviour otherwise identical.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, in_ready = 1 after release, out_valid = 0, sum = 0, cout = 0, ovf = 0, carry and counter = 0.
REQ-026 Reset during RUN or DONE SHALL discard the operation; no out_valid pulse follows release.

Structure
REQ-027 Shared package adder_pkg SHALL hold the FSM state enum and default WIDTH/CHUNK constants.
REQ-028 One sub-module adder_slice: CHUNK-bit ripple add with cin, cout, and carry into MSB; instantiated once.
REQ-029 Counter width SHALL be $clog2(N) with a minimum of 1 bit.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-030 a=0xCB00, b=0x1995, sub=0 -> out_valid 4 cycles after accept, sum=0xE495, cout=0, ovf=0; a=0xCBF0, b=0x0001 -> 0xCBF1.
REQ-031 Carry chain: 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0; 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-032 Subtract: 0x0000-0x0001 -> sum=0xFFFF, cout=0, ovf=0; 0x8000-0x0001 -> sum=0x7FFF, ovf=1.
REQ-033 Backpressure: out_ready low 5 cycles in DONE -> out_valid and sum stable, in_ready=0, in_valid ignored; result consumed on first out_ready.
REQ-034 rst_n low at RUN cycle 2, and separately flush at RUN cycle 2 -> IDLE, no out_valid; next operation 0x1234+0x1111 -> 0x2345.
REQ-035 Re-run REQ-030/031 with CHUNK=16 (latency 1) and CHUNK=1 (latency 16), identical results.
